cam_pixel_packer: RTL

CAM_PIXEL_PACKER -- requirements
Module: cam_pixel_packer

---
 rtl/cam_pixel_packer_if.sv | 21 ++
 rtl/cam_pixel_packer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cam_pixel_packer_if.sv
// rtl/cam_pixel_packer_if.sv - camera input bus and packed pixel output bus
// The packer is the slave; the camera/frame-buffer side is the master.
interface cam_pixel_packer_if;
  logic        I_mode;
  logic        I_vsync;
  logic        I_href;
  logic [9:0]  I_pixdata;
  logic        O_vs_n;
  logic        O_de;
  logic [15:0] O_data;

  modport master (
    output I_mode, I_vsync, I_href, I_pixdata,
    input  O_vs_n, O_de, O_data
  );

  modport slave (
    input  I_mode, I_vsync, I_href, I_pixdata,
    output O_vs_n, O_de, O_data
  );
endinterface

// File: rtl/cam_pixel_packer.sv
// rtl/cam_pixel_packer.sv - camera byte/sample stream to cropped RGB565 pixel packer
// Frames are discarded until SYNC/SKIP complete; a short visible line drops back to SYNC.
module cam_pixel_packer #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SKIP_FRAMES = 2
) (
  input  logic              I_pxl_clk,
  input  logic              I_rst_n,
  cam_pixel_packer_if.slave bus,
  output logic              O_active,
  output logic [11:0]       O_line_len,
  output logic [11:0]       O_frame_lines,
  output logic              O_err
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_SKIP   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [11:0] CNT_MAX  = 12'hFFF;
  localparam logic [12:0] H_LIM    = 13'(H_RES);
  localparam logic [12:0] H2_LIM   = 13'(2 * H_RES);
  localparam logic [12:0] V_LIM    = 13'(V_RES);
  localparam logic [11:0] SKIP_LIM = 12'(SKIP_FRAMES);

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == CNT_MAX) ? v : v + 12'd1;
  endfunction

  logic        vs_q, href_q;
  logic [9:0]  pix_q;
  logic        vs_prev_q, href_prev_q;

  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic [11:0] skip_q, skip_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [11:0] len_q, len_d;
  logic [11:0] line_len_q, line_len_d;
  logic [11:0] frame_lines_q, frame_lines_d;
  logic        err_q, err_d;
  logic        de_q, de_d;
  logic        vs_n_q, vs_n_d;
  logic [15:0] data_q, data_d;

  logic        vs_rise, href_fall, line_short, skip_done;
  logic        sync_go, skip_step;
  logic        pix_valid, in_window;
  logic [12:0] need_len;
  logic [15:0] pix_word;
  logic        unused_pix_lsbs;

  assign unused_pix_lsbs = ^pix_q[1:0];

  always_comb begin
    vs_rise    = vs_q & ~vs_prev_q;
    href_fall  = ~href_q & href_prev_q;
    need_len   = mode_q ? H_LIM : H2_LIM;
    line_short = href_fall && ({1'b0, y_q} < V_LIM) && ({1'b0, len_q} < need_len);
    skip_done  = (sat_inc(skip_q) == SKIP_LIM);
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:   if (vs_rise) state_d = (SKIP_FRAMES == 0) ? ST_ACTIVE : ST_SKIP;
      ST_SKIP:   if (vs_rise && skip_done) state_d = ST_ACTIVE;
      ST_ACTIVE: if (line_short) state_d = ST_SYNC;
      default:   state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    O_active  = (state_q == ST_ACTIVE);
    sync_go   = (state_q == ST_SYNC) && vs_rise;
    skip_step = (state_q == ST_SKIP) && vs_rise;
  end

  // Byte/sample assembly; counters run in every state so measurements stay valid.
  always_comb begin
    phase_d   = 1'b0;
    hi_d      = hi_q;
    x_d       = '0;
    len_d     = '0;
    pix_valid = 1'b0;
    pix_word  = data_q;
    if (href_q) begin
      len_d = sat_inc(len_q);
      x_d   = x_q;
      if (mode_q) begin
        pix_valid = 1'b1;
        pix_word  = {pix_q[9:5], pix_q[9:4], pix_q[9:5]};
      end else begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          hi_d = pix_q[9:2];
        end else begin
          pix_valid = 1'b1;
          pix_word  = {hi_q, pix_q[9:2]};
        end
      end
      if (pix_valid) x_d = sat_inc(x_q);
    end
  end

  always_comb begin
    mode_d = sync_go ? bus.I_mode : mode_q;
    skip_d = skip_q;
    if (sync_go) begin
      skip_d = '0;
    end else if (skip_step) begin
      skip_d = sat_inc(skip_q);
    end

    in_window = O_active && ({1'b0, x_q} < H_LIM) && ({1'b0, y_q} < V_LIM);
    de_d      = pix_valid && in_window;
    data_d    = de_d ? pix_word : data_q;

    // Line length is latched before y clears so a coincident vsync rise counts the line.
    line_len_d = href_fall ? len_q : line_len_q;
    y_d        = href_fall ? sat_inc(y_q) : y_q;
    frame_lines_d = frame_lines_q;
    if (vs_rise) begin
      frame_lines_d = y_d;
      y_d           = '0;
    end

    err_d  = err_q | (O_active && line_short);
    vs_n_d = O_active ? ~vs_q : 1'b1;
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_q          <= 1'b0;
      href_q        <= 1'b0;
      pix_q         <= '0;
      vs_prev_q     <= 1'b0;
      href_prev_q   <= 1'b0;
      mode_q        <= 1'b0;
      skip_q        <= '0;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      len_q         <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      err_q         <= 1'b0;
      de_q          <= 1'b0;
      vs_n_q        <= 1'b1;
      data_q        <= '0;
    end else begin
      vs_q          <= bus.I_vsync;
      href_q        <= bus.I_href;
      pix_q         <= bus.I_pixdata;
      vs_prev_q     <= vs_q;
      href_prev_q   <= href_q;
      mode_q        <= mode_d;
      skip_q        <= skip_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      x_q           <= x_d;
      y_q           <= y_d;
      len_q         <= len_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      err_q         <= err_d;
      de_q          <= de_d;
      vs_n_q        <= vs_n_d;
      data_q        <= data_d;
    end
  end

  assign bus.O_vs_n    = vs_n_q;
  assign bus.O_de      = de_q;
  assign bus.O_data    = data_q;
  assign O_line_len    = line_len_q;
  assign O_frame_lines = frame_lines_q;
  assign O_err         = err_q;

endmodule
